// File: rtl/rx_sync_ctrl_if.sv
// rtl/rx_sync_ctrl_if.sv - decision-stage and slot-timing handshake bundle for rx_sync_ctrl
interface rx_sync_ctrl_if;
  logic        sync_enable_in;
  logic [4:0]  coarse_position_in;
  logic        coarse_syn_success_in;
  logic [6:0]  tr_position_in;
  logic        tr_syn_success_in;
  logic        tr_syn_finish_in;
  logic        tr_syn_en_out;
  logic        sync_lock_out;
  logic        sync_valid_out;
  logic [11:0] slot_offset_out;
  logic [3:0]  miss_cnt_out;
  logic [1:0]  state_out;

  modport master (
    output sync_enable_in, coarse_position_in, coarse_syn_success_in,
           tr_position_in, tr_syn_success_in, tr_syn_finish_in,
    input  tr_syn_en_out, sync_lock_out, sync_valid_out,
           slot_offset_out, miss_cnt_out, state_out
  );

  modport slave (
    input  sync_enable_in, coarse_position_in, coarse_syn_success_in,
           tr_position_in, tr_syn_success_in, tr_syn_finish_in,
    output tr_syn_en_out, sync_lock_out, sync_valid_out,
           slot_offset_out, miss_cnt_out, state_out
  );
endinterface

// File: rtl/rx_sync_ctrl.sv
// rtl/rx_sync_ctrl.sv - receive sync sequencer: coarse search, TR confirmation, lock keeping
module rx_sync_ctrl #(
  parameter logic [15:0] TR_TIMEOUT   = 16'd2000,
  parameter logic [15:0] LOCK_TIMEOUT = 16'd40000,
  parameter int          MISS_MAX     = 3
) (
  input  logic          logic_clk_in,
  input  logic          logic_rst_in,
  rx_sync_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEARCH  = 2'd1,
    TR_WAIT = 2'd2,
    LOCK    = 2'd3
  } state_t;

  localparam logic [15:0] LP_TR_LAST   = TR_TIMEOUT - 16'd1;
  localparam logic [15:0] LP_LOCK_LAST = LOCK_TIMEOUT - 16'd1;
  localparam logic [3:0]  LP_MISS_MAX  = 4'(MISS_MAX);

  state_t      r_state;
  logic [15:0] r_timer;
  logic [4:0]  r_cpos;
  logic [11:0] r_offset;
  logic [3:0]  r_miss;
  logic        r_tr_en;
  logic        r_lock;
  logic        r_valid;

  logic [3:0]  w_miss_next;
  logic        w_hit;

  assign w_miss_next = r_miss + 4'd1;
  assign w_hit       = bus.coarse_syn_success_in && (bus.coarse_position_in == r_cpos);

  always_ff @(posedge logic_clk_in) begin
    if (!logic_rst_in) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_cpos   <= '0;
      r_offset <= '0;
      r_miss   <= '0;
      r_tr_en  <= 1'b0;
      r_lock   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!bus.sync_enable_in) begin
        r_state  <= IDLE;
        r_timer  <= '0;
        r_cpos   <= '0;
        r_offset <= '0;
        r_miss   <= '0;
        r_tr_en  <= 1'b0;
        r_lock   <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_timer <= '0;
            r_state <= SEARCH;
          end
          SEARCH: begin
            if (bus.coarse_syn_success_in) begin
              r_cpos  <= bus.coarse_position_in;
              r_timer <= '0;
              r_tr_en <= 1'b1;
              r_state <= TR_WAIT;
            end
          end
          TR_WAIT: begin
            // A finish on the terminal timer cycle is still honoured.
            if (bus.tr_syn_finish_in) begin
              r_tr_en <= 1'b0;
              r_timer <= '0;
              if (bus.tr_syn_success_in) begin
                r_offset <= {r_cpos, bus.tr_position_in};
                r_valid  <= 1'b1;
                r_lock   <= 1'b1;
                r_miss   <= '0;
                r_state  <= LOCK;
              end else begin
                r_state <= SEARCH;
              end
            end else if (r_timer == LP_TR_LAST) begin
              r_tr_en <= 1'b0;
              r_timer <= '0;
              r_state <= SEARCH;
            end else begin
              r_timer <= r_timer + 16'd1;
            end
          end
          LOCK: begin
            // A coarse pulse on the timeout cycle supersedes the timeout.
            if (w_hit) begin
              r_miss  <= '0;
              r_timer <= '0;
            end else if (bus.coarse_syn_success_in || (r_timer == LP_LOCK_LAST)) begin
              r_timer <= '0;
              if (w_miss_next >= LP_MISS_MAX) begin
                r_miss  <= LP_MISS_MAX;
                r_lock  <= 1'b0;
                r_state <= SEARCH;
              end else begin
                r_miss <= w_miss_next;
              end
            end else begin
              r_timer <= r_timer + 16'd1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.tr_syn_en_out   = r_tr_en;
  assign bus.sync_lock_out   = r_lock;
  assign bus.sync_valid_out  = r_valid;
  assign bus.slot_offset_out = r_offset;
  assign bus.miss_cnt_out    = r_miss;
  assign bus.state_out       = r_state;

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// tb/tb_rx_sync_ctrl.sv - directed self-checking bench for rx_sync_ctrl
module tb_rx_sync_ctrl;

  localparam logic [15:0] TR_TO   = 16'd2000;
  localparam logic [15:0] LOCK_TO = 16'd400;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  rx_sync_ctrl_if bus ();

  rx_sync_ctrl #(
    .TR_TIMEOUT  (TR_TO),
    .LOCK_TIMEOUT(LOCK_TO),
    .MISS_MAX    (3)
  ) dut (
    .logic_clk_in(clk),
    .logic_rst_in(rst_n),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #2.5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic coarse(input logic [4:0] pos);
    bus.coarse_position_in    = pos;
    bus.coarse_syn_success_in = 1'b1;
    tick();
    bus.coarse_syn_success_in = 1'b0;
  endtask

  task automatic finish(input logic ok, input logic [6:0] pos);
    bus.tr_position_in    = pos;
    bus.tr_syn_success_in = ok;
    bus.tr_syn_finish_in  = 1'b1;
    tick();
    bus.tr_syn_finish_in  = 1'b0;
    bus.tr_syn_success_in = 1'b0;
  endtask

  function automatic logic [31:0] outs();
    return {11'd0, bus.tr_syn_en_out, bus.sync_lock_out, bus.sync_valid_out,
            bus.slot_offset_out, bus.miss_cnt_out, bus.state_out};
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n                     = 1'b0;
    bus.sync_enable_in        = 1'b0;
    bus.coarse_position_in    = '0;
    bus.coarse_syn_success_in = 1'b0;
    bus.tr_position_in        = '0;
    bus.tr_syn_success_in     = 1'b0;
    bus.tr_syn_finish_in      = 1'b0;
    ticks(2);
    chk("reset_outputs", outs(), 32'd0);

    rst_n = 1'b1;
    bus.sync_enable_in = 1'b1;
    tick();
    chk("enter_search", {30'd0, bus.state_out}, 32'd1);

    // acquire
    coarse(5'd9);
    chk("coarse_state", {30'd0, bus.state_out}, 32'd2);
    chk("coarse_tr_en", {31'd0, bus.tr_syn_en_out}, 32'd1);
    ticks(99);
    finish(1'b1, 7'd33);
    chk("acq_valid", {31'd0, bus.sync_valid_out}, 32'd1);
    chk("acq_offset", {20'd0, bus.slot_offset_out}, 32'h4A1);
    chk("acq_lock", {31'd0, bus.sync_lock_out}, 32'd1);
    chk("acq_state", {30'd0, bus.state_out}, 32'd3);
    chk("acq_tr_en", {31'd0, bus.tr_syn_en_out}, 32'd0);
    tick();
    chk("valid_one_cycle", {31'd0, bus.sync_valid_out}, 32'd0);

    // lock maintenance; last hit lands on the timeout terminal cycle
    for (int k = 0; k < 3; k++) begin
      ticks(299);
      coarse(5'd9);
      chk("maint_miss", {28'd0, bus.miss_cnt_out}, 32'd0);
    end
    ticks(399);
    coarse(5'd9);
    chk("hit_on_timeout_miss", {28'd0, bus.miss_cnt_out}, 32'd0);
    chk("hit_on_timeout_lock", {31'd0, bus.sync_lock_out}, 32'd1);
    coarse(5'd10);
    chk("wrong_pos_miss", {28'd0, bus.miss_cnt_out}, 32'd1);
    chk("wrong_pos_offset", {20'd0, bus.slot_offset_out}, 32'h4A1);
    chk("wrong_pos_valid", {31'd0, bus.sync_valid_out}, 32'd0);
    coarse(5'd9);
    chk("rehit_miss", {28'd0, bus.miss_cnt_out}, 32'd0);

    // lock loss by consecutive timeouts
    ticks(399);
    chk("pre_timeout_miss", {28'd0, bus.miss_cnt_out}, 32'd0);
    tick();
    chk("timeout1_miss", {28'd0, bus.miss_cnt_out}, 32'd1);
    ticks(400);
    chk("timeout2_miss", {28'd0, bus.miss_cnt_out}, 32'd2);
    chk("timeout2_lock", {31'd0, bus.sync_lock_out}, 32'd1);
    ticks(400);
    chk("loss_lock", {31'd0, bus.sync_lock_out}, 32'd0);
    chk("loss_state", {30'd0, bus.state_out}, 32'd1);
    chk("loss_offset", {20'd0, bus.slot_offset_out}, 32'h4A1);

    // TR failure
    coarse(5'd3);
    ticks(10);
    finish(1'b0, 7'd1);
    chk("trfail_state", {30'd0, bus.state_out}, 32'd1);
    chk("trfail_tr_en", {31'd0, bus.tr_syn_en_out}, 32'd0);
    chk("trfail_lock", {31'd0, bus.sync_lock_out}, 32'd0);

    // TR timeout: enable falls exactly TR_TO cycles after rising
    coarse(5'd4);
    ticks(1999);
    chk("trto_still_en", {31'd0, bus.tr_syn_en_out}, 32'd1);
    tick();
    chk("trto_en_drop", {31'd0, bus.tr_syn_en_out}, 32'd0);
    chk("trto_state", {30'd0, bus.state_out}, 32'd1);

    // finish on the TR timeout terminal cycle wins
    coarse(5'd7);
    ticks(1999);
    finish(1'b1, 7'd5);
    chk("corner_lock", {31'd0, bus.sync_lock_out}, 32'd1);
    chk("corner_state", {30'd0, bus.state_out}, 32'd3);
    chk("corner_offset", {20'd0, bus.slot_offset_out}, 32'h385);
    chk("corner_valid", {31'd0, bus.sync_valid_out}, 32'd1);

    // reset while locked
    ticks(5);
    rst_n = 1'b0;
    tick();
    chk("reset_in_lock", outs(), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_reset_search", {30'd0, bus.state_out}, 32'd1);

    // disable during TR_WAIT
    coarse(5'd9);
    chk("dis_pre_state", {30'd0, bus.state_out}, 32'd2);
    bus.sync_enable_in = 1'b0;
    tick();
    chk("disable_outputs", outs(), 32'd0);
    tick();
    chk("disable_hold_idle", outs(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_sync_ctrl.md
# rx_sync_ctrl

Receive-synchronisation sequencer that sits directly downstream of `rx_decision_top`. It consumes the coarse (SYNC PN) decision and the TR S0 decision, and drives the TR search enable back into the decision stage. It sequences search, TR confirmation and lock, and publishes a registered 12-bit slot timing offset plus a lock flag to the slot-timing logic. Lock is held through transient misses and dropped after a configurable number of consecutive failures.

## Interface
- `TR_TIMEOUT`, 16'd2000: cycles to wait for `tr_syn_finish_in` after TR search is armed.
- `LOCK_TIMEOUT`, 16'd40000: cycles allowed between consecutive coarse successes while locked.
- `MISS_MAX`, 3: consecutive misses in LOCK that drop lock (range 1–15).
- `logic_clk_in` in 1: 200 MHz logic clock; the only clock.
- `logic_rst_in` in 1: synchronous, active-low reset.
- `sync_enable_in` in 1: level; 0 forces IDLE.
- `coarse_position_in` in 5: coarse position, valid with the success pulse.
- `coarse_syn_success_in` in 1: one-cycle pulse.
- `tr_position_in` in 7: TR position, valid with `tr_syn_finish_in`.
- `tr_syn_success_in` in 1: TR result qualifier, sampled only with finish.
- `tr_syn_finish_in` in 1: one-cycle pulse, end of TR search.
- `tr_syn_en_out` out 1: level; TR search enable toward the decision stage.
- `sync_lock_out` out 1: level; receiver is locked.
- `sync_valid_out` out 1: one-cycle pulse when a new offset is loaded.
- `slot_offset_out` out 12: {coarse_position, tr_position}.
- `miss_cnt_out` out 4: current consecutive miss count.
- `state_out` out 2: IDLE=0, SEARCH=1, TR_WAIT=2, LOCK=3.

## Operation
- **IDLE:** all outputs are cleared. Go to SEARCH when `sync_enable_in`=1.
- **SEARCH:**
  - On a `coarse_syn_success_in` pulse: latch `coarse_position_in` into `cpos_r`, clear the timer, go to TR_WAIT.
  - `tr_syn_en_out` goes to 1 on entry to TR_WAIT.
- **TR_WAIT:** `tr_syn_en_out`=1 and the 16-bit timer increments each cycle.
  - `tr_syn_finish_in`=1 with `tr_syn_success_in`=1:
    - load `slot_offset_out` = {`cpos_r`, `tr_position_in`} and pulse `sync_valid_out`;
    - set `sync_lock_out` and clear `miss_cnt_out`;
    - clear the timer and go to LOCK.
  - `tr_syn_finish_in`=1 with `tr_syn_success_in`=0: go to SEARCH.
  - Timer reaches `TR_TIMEOUT`-1 with no finish: go to SEARCH.
  - `tr_syn_en_out` drops to 0 on leaving TR_WAIT.
  - Coarse pulses in TR_WAIT are ignored.
- **LOCK:** the timer increments each cycle.
  - Coarse pulse with position equal to `cpos_r`: hit. Clear miss count and timer.
  - Coarse pulse with a different position: miss. Increment miss count, clear the timer; `cpos_r` and `slot_offset_out` are unchanged.
  - Timer reaches `LOCK_TIMEOUT`-1: miss. Increment miss count, clear the timer.
  - If a miss makes the count reach `MISS_MAX`: clear `sync_lock_out`, go to SEARCH.
  - `slot_offset_out` holds its last value after lock loss; it changes only together with `sync_valid_out`.
- **Disable:** `sync_enable_in`=0 in any state forces IDLE next cycle. Lock, enable and miss count are cleared; `slot_offset_out` is cleared.
- **Arithmetic and width rules:**
  - Timer is 16-bit and never wraps; it is always cleared at its terminal value.
  - Miss count is 4-bit and saturates at `MISS_MAX`.

## Timing
- All outputs are registered. Reset values: every output is 0, state is IDLE, timer is 0, `cpos_r` is 0.
- Reset has priority over enable; enable has priority over all events.
- Latency from an input pulse at cycle N to the response at N+1:
  - coarse pulse in SEARCH → `tr_syn_en_out`=1 and `state_out`=2;
  - finish with success → `sync_valid_out`, `sync_lock_out` and the new offset.
- Simultaneous events:
  - finish and TR timeout in the same cycle: finish wins.
  - coarse pulse and LOCK timeout in the same cycle: the coarse pulse is evaluated and the timeout is discarded (counted as at most one miss).
- Reset (`logic_rst_in`=0) in mid-operation returns to IDLE on the next clock edge with all outputs 0.

## Test plan
- **Acquire:** enable, coarse pulse pos=5'd9, then finish+success with tr_pos=7'd33 after 100 cycles → `sync_valid_out` for one cycle, `slot_offset_out`=12'h4A1, lock=1, state=3.
- **TR fail / timeout:**
  - finish with success=0 → state returns to 1, `tr_syn_en_out`=0, lock=0.
  - No finish for 2000 cycles → SEARCH, with `tr_syn_en_out` dropping exactly 2000 cycles after it rose.
- **Lock maintenance:** in LOCK, a coarse pulse pos=9 every 30000 cycles → miss count stays 0; a pulse pos=10 → miss count 1, offset unchanged.
- **Lock loss:** no coarse pulses for 3×40000 cycles → miss count 1, 2, then lock=0 and state=1; the offset keeps 12'h4A1.
- **Priority / corners:**
  - Finish coincident with the timeout terminal cycle → lock acquired.
  - `sync_enable_in`=0 in TR_WAIT → IDLE next cycle, all outputs 0.
  - Reset asserted while in LOCK → all outputs 0 next cycle.
